// File: rtl/n4v68k_bus_pkg.sv
// Shared types and constants for the 68000-strobe to cyc/stb bus bridge.
package n4v68k_bus_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned TMR_W = 8;

  localparam logic [2:0]       FC_CPU_SPACE     = 3'b111;
  localparam logic [TMR_W-1:0] DEF_BERR_TIMEOUT = 8'd200;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACKD,
    BERR,
    IACK
  } state_e;

endpackage

// File: rtl/n4v68k_bus_timer.sv
// Clearable, saturating 8-bit cycle counter with a terminal-count flag.
module n4v68k_bus_timer
  import n4v68k_bus_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [TMR_W-1:0] tc_val_i,
  output logic             tc_c_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/n4v68k_bus_bridge.sv
// 68000 strobe bus to single-master cyc/stb bus bridge in front of the MMU.
// Define BUS_BERR_TIMEOUT_EN to build the no-ack bus-error timer and BERR state.
module n4v68k_bus_bridge
  import n4v68k_bus_pkg::*;
#(
  parameter logic [2:0] IACK_FC = FC_CPU_SPACE
`ifdef BUS_BERR_TIMEOUT_EN
  , parameter logic [TMR_W-1:0] BERR_TIMEOUT = DEF_BERR_TIMEOUT
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             as_ni,
  input  logic             uds_ni,
  input  logic             lds_ni,
  input  logic             rw_i,
  input  logic [2:0]       fc_i,
  input  logic [31:1]      cpu_adr_i,
  input  logic [DAT_W-1:0] cpu_dat_i,
  output logic [DAT_W-1:0] cpu_dat_o,
  output logic             dtack_no,
  output logic             berr_no,
  input  logic [7:0]       vec_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [1:0]       sel_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] wb_dat_o,
  input  logic [DAT_W-1:0] wb_dat_i,
  input  logic             ack_i
);

  state_e           state_q, state_d;
  logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic             dtack_q, dtack_d, berr_q, berr_d;
  logic [1:0]       sel_q, sel_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wb_dat_q, wb_dat_d, cpu_dat_q, cpu_dat_d;
  logic             req_c, timeout_c;

  // Data strobes gate the request so writes wait for valid data.
  assign req_c = !as_ni && (!uds_ni || !lds_ni);

`ifdef BUS_BERR_TIMEOUT_EN
  n4v68k_bus_timer u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_q != REQ),
    .en_i     (state_q == REQ),
    .tc_val_i (TMR_W'(BERR_TIMEOUT - 8'd1)),
    .tc_c_o   (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    wb_dat_d  = wb_dat_q;
    cpu_dat_d = cpu_dat_q;
    dtack_d   = dtack_q;
    berr_d    = berr_q;
    unique case (state_q)
      IDLE: begin
        if (req_c && !ack_i) begin
          if (fc_i == IACK_FC) begin
            cpu_dat_d = {8'h00, vec_i};
            state_d   = IACK;
          end else begin
            adr_d    = {cpu_adr_i, 1'b0};
            sel_d    = {~uds_ni, ~lds_ni};
            we_d     = ~rw_i;
            wb_dat_d = cpu_dat_i;
            cyc_d    = 1'b1;
            stb_d    = 1'b1;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        // Ack beats a same-edge timeout; abort only when neither fired.
        if (ack_i) begin
          if (!we_q) cpu_dat_d = wb_dat_i;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          dtack_d = 1'b0;
          state_d = ACKD;
        end else if (timeout_c) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          berr_d  = 1'b0;
          state_d = BERR;
        end else if (as_ni) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ACKD;
        end
      end
      ACKD: begin
        if (as_ni) dtack_d = 1'b1;
        if (as_ni && !ack_i) state_d = IDLE;
      end
      BERR: begin
        if (as_ni) begin
          berr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      IACK: begin
        dtack_d = 1'b0;
        state_d = ACKD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      wb_dat_q  <= '0;
      cpu_dat_q <= '0;
      dtack_q   <= 1'b1;
      berr_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      wb_dat_q  <= wb_dat_d;
      cpu_dat_q <= cpu_dat_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
    end
  end

  assign cyc_o     = cyc_q;
  assign stb_o     = stb_q;
  assign we_o      = we_q;
  assign sel_o     = sel_q;
  assign adr_o     = adr_q;
  assign wb_dat_o  = wb_dat_q;
  assign cpu_dat_o = cpu_dat_q;
  assign dtack_no  = dtack_q;
`ifdef BUS_BERR_TIMEOUT_EN
  assign berr_no   = berr_q;
`else
  assign berr_no   = 1'b1;
`endif

endmodule

// File: tb/tb_n4v68k_bus_bridge.sv
// Scoreboard bench for n4v68k_bus_bridge: expected read data queued at request, checked at dtack.
module tb_n4v68k_bus_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        as_ni, uds_ni, lds_ni, rw_i, ack_i;
  logic [2:0]  fc_i;
  logic [31:1] cpu_adr_i;
  logic [15:0] cpu_dat_i, cpu_dat_o, wb_dat_i, wb_dat_o;
  logic        dtack_no, berr_no, cyc_o, stb_o, we_o;
  logic [7:0]  vec_i;
  logic [1:0]  sel_o;
  logic [31:0] adr_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_dat[$];

  always #5 clk_i = ~clk_i;

  n4v68k_bus_bridge #(
`ifdef BUS_BERR_TIMEOUT_EN
    .BERR_TIMEOUT (8'd10),
`endif
    .IACK_FC      (3'b111)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .as_ni     (as_ni),
    .uds_ni    (uds_ni),
    .lds_ni    (lds_ni),
    .rw_i      (rw_i),
    .fc_i      (fc_i),
    .cpu_adr_i (cpu_adr_i),
    .cpu_dat_i (cpu_dat_i),
    .cpu_dat_o (cpu_dat_o),
    .dtack_no  (dtack_no),
    .berr_no   (berr_no),
    .vec_i     (vec_i),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .sel_o     (sel_o),
    .adr_o     (adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .ack_i     (ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cpu_req(input logic [31:0] byte_adr, input logic uds, input logic lds,
                         input logic rw, input logic [2:0] fc, input logic [15:0] dat);
    cpu_adr_i = byte_adr[31:1];
    uds_ni    = uds;
    lds_ni    = lds;
    rw_i      = rw;
    fc_i      = fc;
    cpu_dat_i = dat;
    as_ni     = 1'b0;
  endtask

  task automatic cpu_end();
    as_ni  = 1'b1;
    uds_ni = 1'b1;
    lds_ni = 1'b1;
  endtask

  // Pop the oldest expected read value and compare it with the data presented at dtack.
  task automatic check_dtack(input string tag);
    logic [15:0] e;
    chk({tag, "_dtack"}, 32'(dtack_no), 32'h0);
    chk({tag, "_sb_avail"}, 32'(exp_dat.size() > 0), 32'h1);
    if (exp_dat.size() > 0) begin
      e = exp_dat.pop_front();
      chk({tag, "_dat"}, 32'(cpu_dat_o), 32'(e));
    end
  endtask

  initial begin
    int n;
    rst_ni = 1'b0; as_ni = 1'b1; uds_ni = 1'b1; lds_ni = 1'b1; rw_i = 1'b1;
    fc_i = 3'b101; cpu_adr_i = '0; cpu_dat_i = '0; wb_dat_i = '0; ack_i = 1'b0; vec_i = '0;
    #12;
    chk("rst_cyc", 32'(cyc_o), 32'h0);
    chk("rst_stb", 32'(stb_o), 32'h0);
    chk("rst_we", 32'(we_o), 32'h0);
    chk("rst_sel", 32'(sel_o), 32'h0);
    chk("rst_adr", adr_o, 32'h0);
    chk("rst_wbdat", 32'(wb_dat_o), 32'h0);
    chk("rst_cpudat", 32'(cpu_dat_o), 32'h0);
    chk("rst_dtack", 32'(dtack_no), 32'h1);
    chk("rst_berr", 32'(berr_no), 32'h1);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    tick();

    // Word read, MMU acks in the cycle after stb rises.
    exp_dat.push_back(16'hBEEF);
    cpu_req(32'h0000_1234, 1'b0, 1'b0, 1'b1, 3'b101, 16'h0000);
    tick();
    chk("rd_cyc", 32'(cyc_o), 32'h1);
    chk("rd_stb", 32'(stb_o), 32'h1);
    chk("rd_adr", adr_o, 32'h0000_1234);
    chk("rd_sel", 32'(sel_o), 32'h3);
    chk("rd_we", 32'(we_o), 32'h0);
    chk("rd_nodtack", 32'(dtack_no), 32'h1);
    ack_i = 1'b1; wb_dat_i = 16'hBEEF;
    tick();
    check_dtack("rd");
    chk("rd_stb_drop", 32'(stb_o), 32'h0);
    ack_i = 1'b0; cpu_end();
    tick();
    chk("rd_release", 32'(dtack_no), 32'h1);
    tick();

    // Byte write; read data register must hold its previous value.
    exp_dat.push_back(16'hBEEF);
    cpu_req(32'h0000_2001, 1'b1, 1'b0, 1'b0, 3'b101, 16'h0055);
    tick();
    chk("wr_we", 32'(we_o), 32'h1);
    chk("wr_sel", 32'(sel_o), 32'h1);
    chk("wr_dat", 32'(wb_dat_o), 32'h0055);
    chk("wr_adr", adr_o, 32'h0000_2000);
    ack_i = 1'b1;
    tick();
    chk("wr_we_drop", 32'(we_o), 32'h0);
    check_dtack("wr");
    ack_i = 1'b0; cpu_end();
    tick();
    tick();

    // Walked translation: ack held past stb fall, then a request waits on ack in IDLE.
    exp_dat.push_back(16'hCAFE);
    cpu_req(32'h0000_4000, 1'b0, 1'b0, 1'b1, 3'b101, 16'h0000);
    tick();
    ack_i = 1'b1; wb_dat_i = 16'hCAFE;
    tick();
    check_dtack("walk");
    cpu_end();
    tick();
    chk("walk_release", 32'(dtack_no), 32'h1);
    chk("walk_cyc0", 32'(cyc_o), 32'h0);
    tick();
    chk("walk_cyc1", 32'(cyc_o), 32'h0);
    ack_i = 1'b0;
    tick();
    cpu_req(32'h0000_6000, 1'b0, 1'b0, 1'b1, 3'b101, 16'h0000);
    ack_i = 1'b1;
    tick();
    chk("gate_cyc0", 32'(cyc_o), 32'h0);
    tick();
    chk("gate_cyc1", 32'(cyc_o), 32'h0);
    ack_i = 1'b0;
    tick();
    chk("gate_start", 32'(cyc_o), 32'h1);
    chk("gate_adr", adr_o, 32'h0000_6000);
    exp_dat.push_back(16'h1111);
    ack_i = 1'b1; wb_dat_i = 16'h1111;
    tick();
    check_dtack("gate");
    ack_i = 1'b0; cpu_end();
    tick();
    tick();

    // Interrupt acknowledge answered locally.
    vec_i = 8'h40;
    exp_dat.push_back(16'h0040);
    cpu_req(32'h0000_0FFE, 1'b1, 1'b0, 1'b1, 3'b111, 16'h0000);
    tick();
    chk("iack_cyc0", 32'(cyc_o), 32'h0);
    chk("iack_early", 32'(dtack_no), 32'h1);
    tick();
    check_dtack("iack");
    chk("iack_cyc1", 32'(cyc_o), 32'h0);
    cpu_end();
    tick();
    chk("iack_release", 32'(dtack_no), 32'h1);
    tick();

    // Aborted cycle: as_ni rises without ack, no dtack.
    cpu_req(32'h0000_8000, 1'b0, 1'b0, 1'b1, 3'b101, 16'h0000);
    tick();
    chk("abort_cyc", 32'(cyc_o), 32'h1);
    tick();
    tick();
    cpu_end();
    tick();
    chk("abort_drop", 32'(cyc_o), 32'h0);
    chk("abort_nodtack", 32'(dtack_no), 32'h1);
    tick();

    // No ack at all.
    cpu_req(32'h0000_A000, 1'b0, 1'b0, 1'b1, 3'b101, 16'h0000);
    tick();
    chk("to_stb", 32'(stb_o), 32'h1);
`ifdef BUS_BERR_TIMEOUT_EN
    n = 0;
    while (berr_no === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("berr_latency", 32'(n), 32'd10);
    chk("berr_cyc", 32'(cyc_o), 32'h0);
    chk("berr_stb", 32'(stb_o), 32'h0);
    cpu_end();
    tick();
    chk("berr_release", 32'(berr_no), 32'h1);
`else
    n = 0;
    repeat (20) begin
      tick();
      n++;
    end
    chk("noto_berr", 32'(berr_no), 32'h1);
    chk("noto_cyc", 32'(cyc_o), 32'h1);
    cpu_end();
    tick();
    chk("noto_abort", 32'(cyc_o), 32'h0);
    chk("noto_nodtack", 32'(dtack_no), 32'h1);
`endif
    tick();

    // Asynchronous reset while a request is outstanding.
    cpu_req(32'h0000_C000, 1'b0, 1'b0, 1'b1, 3'b101, 16'h0000);
    tick();
    chk("arst_pre", 32'(cyc_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_cyc", 32'(cyc_o), 32'h0);
    chk("arst_stb", 32'(stb_o), 32'h0);
    chk("arst_dtack", 32'(dtack_no), 32'h1);
    chk("arst_berr", 32'(berr_no), 32'h1);
    chk("arst_adr", adr_o, 32'h0);
    cpu_end();
    @(posedge clk_i); #1 rst_ni = 1'b1;
    tick();

    chk("sb_empty", 32'(exp_dat.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
